tmw_sampler: RTL and testbench
==============================

# tmw_sampler

Sampling controller and bit extractor on the consumer side of `tmw_counter` in the TRNG datapath. It runs back-to-back time-measurement windows by driving the window counter's enable and limit, and waits for each window to close. It then reads the ring-oscillator edge count, folds its low bits into one raw random bit, and packs the bits into words. Words leave through a valid/ready stream towards the post-processing stage.

## Interface
- `WIDTH`, default 5: width of the window count; matches the `tmw_counter` `WIDTH`.
- `CW`, default 16: width of the ring-oscillator edge count `ro_cnt_i`.
- `XOR_BITS`, default 1: number of low bits of `ro_cnt_i` XOR-folded into one raw bit; legal range 1..`CW`.
- `SETTLE_CYC`, default 2: wait cycles after a window closes before `ro_cnt_i` is read; legal range ≥1. Covers the RO counter synchroniser.
- `OUT_W`, default 8: number of bits per output word.
- `ARM_TO`, default 4: ARM-state timeout in cycles.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start_i`  in  1  level; run continuous sampling while high.
- `window_i`  in  `WIDTH`  window length in cycles; latched in CLEAR.
- `tmw_en_o`  out  1  drives the counter `en_i`.
- `tmw_max_o`  out  `WIDTH`  drives the counter `max_counts_i`.
- `tmw_ro_en_i`  in  1  the counter's `ro_en_o`.
- `ro_cnt_i`  in  `CW`  synchronised RO edge count.
- `ro_cnt_clr_o`  out  1  one-cycle clear pulse to the RO edge counter.
- `rnd_data_o`  out  `OUT_W`  packed random word.
- `rnd_valid_o`  out  1  word valid.
- `rnd_ready_i`  in  1  sink ready.
- `err_o`  out  1  sticky: an ARM timeout has occurred.

## Operation
- FSM states: IDLE, CLEAR, ARM, RUN, SETTLE, CAPTURE, OUTPUT. All outputs are registered or Moore-decoded from the state.
- **IDLE**: `tmw_en_o`=0. Go to CLEAR when `start_i`=1.
- **CLEAR** (1 cycle):
  - `ro_cnt_clr_o`=1 and `tmw_en_o`=0.
  - Latch `tmw_max_o` = `window_i`, or 1 if `window_i`=0 (clamp).
  - Go to ARM.
- **ARM**:
  - `tmw_en_o`=1.
  - Go to RUN when `tmw_ro_en_i`=1.
  - If `tmw_ro_en_i` is not seen high within `ARM_TO` cycles: set `err_o`, return to CLEAR, no bit recorded.
- **RUN**: `tmw_en_o`=1. Go to SETTLE when `tmw_ro_en_i`=0.
- **SETTLE**: `tmw_en_o`=0. Stay `SETTLE_CYC` cycles, then go to CAPTURE.
- **CAPTURE** (1 cycle):
  - bit = XOR of `ro_cnt_i[XOR_BITS-1:0]`.
  - Shift the bit into the shift register from the LSB side (left shift); the first bit captured ends at the MSB.
  - Increment the bit count.
  - If the bit count = `OUT_W`: load `rnd_data_o`, clear the bit count, go to OUTPUT.
  - Otherwise go to CLEAR if `start_i`=1, else IDLE.
- **OUTPUT**:
  - `rnd_valid_o`=1 and `rnd_data_o` held stable.
  - On `rnd_valid_o`&`rnd_ready_i`: drop valid, then go to CLEAR if `start_i`=1, else IDLE.
  - No sampling while OUTPUT waits (full backpressure, no skid buffer).
- A partial word is kept across IDLE; sampling resumes from the stored bit count.
- `start_i` is sampled only in IDLE, at the end of CAPTURE and at the OUTPUT transfer. Deassertion never aborts a window in progress.
- `err_o` is cleared only by `rst`.

## Timing
- Reset values: state IDLE, `tmw_en_o`=0, `tmw_max_o`=1, `ro_cnt_clr_o`=0, `rnd_data_o`=0, `rnd_valid_o`=0, `err_o`=0, bit count 0, shift register 0.
- Reset mid-operation: all of the above on the next edge; the partial word is discarded.
- Cycle numbering, taking CLEAR as cycle 0:
  - Cycle 1: ARM; `tmw_en_o`=1.
  - Cycle 2: `tmw_ro_en_i` seen high; RUN entered at cycle 3.
  - `tmw_ro_en_i` is high for W cycles (cycles 2..W+1) and first low at cycle W+2.
  - SETTLE covers cycles W+3..W+2+`SETTLE_CYC`.
  - CAPTURE is at cycle W+3+`SETTLE_CYC`.
  - The next CLEAR is at cycle W+4+`SETTLE_CYC`.
- Sample period: W+4+`SETTLE_CYC` cycles (10 at W=4, `SETTLE_CYC`=2).
- Word latency with `rnd_ready_i`=1: `OUT_W` periods plus 1 OUTPUT cycle.
- `tmw_max_o` changes only in CLEAR, while `tmw_en_o`=0.

## Test plan
- **Basic window.** `WIDTH`=5, `window_i`=4, `SETTLE_CYC`=2, `start_i`=1.
  - `ro_cnt_clr_o` pulses every 10 cycles.
  - `tmw_ro_en_i` is high for exactly 4 cycles per sample.
  - `tmw_max_o`=4.
- **Word packing.** `OUT_W`=8, `XOR_BITS`=1, `ro_cnt_i` LSB sequence 1,0,1,1,0,0,1,0 → `rnd_data_o`=8'hB2 with `rnd_valid_o`=1.
- **XOR fold.** `XOR_BITS`=3, `ro_cnt_i`=16'h0006 → captured bit 0; `ro_cnt_i`=16'h0007 → captured bit 1.
- **Backpressure.** `rnd_ready_i`=0 for 20 cycles after valid:
  - `rnd_data_o` stays stable and valid stays high.
  - `tmw_en_o` and `ro_cnt_clr_o` stay 0 throughout.
  - The next CLEAR comes 1 cycle after the transfer.
- **Zero window.** `window_i`=0 → `tmw_max_o`=1, the window runs normally and `err_o` stays 0.
- **Timeout and reset.**
  - Tie `tmw_ro_en_i`=0 → `err_o`=1 after 4 ARM cycles, then the FSM re-enters CLEAR.
  - Assert `rst` during RUN → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/tmw_sampler_if.sv
// Random-word stream from tmw_sampler to post-processing.
// Valid/ready handshake; data held stable while valid waits.
interface tmw_sampler_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] rnd_data_o;
  logic             rnd_valid_o;
  logic             rnd_ready_i;

  modport master (
    output rnd_data_o,
    output rnd_valid_o,
    input  rnd_ready_i
  );

  modport slave (
    input  rnd_data_o,
    input  rnd_valid_o,
    output rnd_ready_i
  );
endinterface

// File: rtl/tmw_sampler.sv
// TRNG sampler: runs tmw_counter windows, folds RO counts to bits,
// packs bits into words and streams them out.
module tmw_sampler #(
  parameter int WIDTH      = 5,
  parameter int CW         = 16,
  parameter int XOR_BITS   = 1,
  parameter int SETTLE_CYC = 2,
  parameter int OUT_W      = 8,
  parameter int ARM_TO     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] window_i,
  output logic             tmw_en_o,
  output logic [WIDTH-1:0] tmw_max_o,
  input  logic             tmw_ro_en_i,
  input  logic [CW-1:0]    ro_cnt_i,
  output logic             ro_cnt_clr_o,
  output logic             err_o,
  tmw_sampler_if.master    rnd
);

  localparam int TMAX =
    (ARM_TO > SETTLE_CYC) ? ARM_TO : SETTLE_CYC;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int BW = $clog2(OUT_W + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, ARM, RUN,
    SETTLE, CAPTURE, OUTPUT
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0]    tmr_q;
  logic [OUT_W-1:0] sh_q, sh_d;
  logic [OUT_W-1:0] data_q;
  logic [BW-1:0]    bcnt_q, bcnt_inc;
  logic [WIDTH-1:0] max_q;
  logic             err_q;
  logic             rnd_bit;
  logic             word_full;
  logic             arm_to;
  logic             settle_done;
  logic             unused_ro;

  assign unused_ro   = ^ro_cnt_i;
  assign rnd_bit     = ^ro_cnt_i[XOR_BITS-1:0];
  assign sh_d        = (sh_q << 1) | OUT_W'(rnd_bit);
  assign bcnt_inc    = bcnt_q + BW'(1);
  assign word_full   = bcnt_inc == BW'(OUT_W);
  assign arm_to      = tmr_q == TW'(ARM_TO - 1);
  assign settle_done = tmr_q == TW'(SETTLE_CYC - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = CLEAR;
      CLEAR:   state_d = ARM;
      ARM: begin
        if (tmw_ro_en_i) state_d = RUN;
        else if (arm_to) state_d = CLEAR;
      end
      RUN:     if (!tmw_ro_en_i) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = CAPTURE;
      CAPTURE: begin
        if (word_full)    state_d = OUTPUT;
        else if (start_i) state_d = CLEAR;
        else              state_d = IDLE;
      end
      OUTPUT: begin
        if (rnd.rnd_ready_i)
          state_d = start_i ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      max_q   <= WIDTH'(1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // one timer serves both the ARM timeout and SETTLE wait
      if (state_d != state_q)
        tmr_q <= '0;
      else if (state_q == ARM || state_q == SETTLE)
        tmr_q <= tmr_q + TW'(1);
      if (state_q == CLEAR)
        max_q <= (window_i == '0) ? WIDTH'(1) : window_i;
      if (state_q == ARM && !tmw_ro_en_i && arm_to)
        err_q <= 1'b1;
      if (state_q == CAPTURE) begin
        sh_q <= sh_d;
        if (word_full) begin
          data_q <= sh_d;
          bcnt_q <= '0;
        end else begin
          bcnt_q <= bcnt_inc;
        end
      end
    end
  end

  assign tmw_en_o        = (state_q == ARM) || (state_q == RUN);
  assign ro_cnt_clr_o    = state_q == CLEAR;
  assign tmw_max_o       = max_q;
  assign err_o           = err_q;
  assign rnd.rnd_valid_o = state_q == OUTPUT;
  assign rnd.rnd_data_o  = data_q;

endmodule

// File: tb/tb_tmw_sampler.sv
// Directed bench for tmw_sampler with a behavioural
// window-counter model driving tmw_ro_en_i.
module tb_tmw_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  window;
  logic        tmw_en;
  logic [4:0]  tmw_max;
  logic        ro_en = 1'b0;
  logic [15:0] ro_cnt;
  logic        clr;
  logic        err;
  bit          tie_low = 1'b0;
  int          mcnt = 0;
  logic        done = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  tmw_sampler_if #(.OUT_W(8)) rnd_if ();

  tmw_sampler #(
    .WIDTH(5), .CW(16), .XOR_BITS(3),
    .SETTLE_CYC(2), .OUT_W(8), .ARM_TO(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .window_i(window),
    .tmw_en_o(tmw_en),
    .tmw_max_o(tmw_max),
    .tmw_ro_en_i(ro_en),
    .ro_cnt_i(ro_cnt),
    .ro_cnt_clr_o(clr),
    .err_o(err),
    .rnd(rnd_if)
  );

  always #5 clk = ~clk;

  // window counter: ro_en high for max cycles,
  // starting the cycle after en is seen
  always @(posedge clk) begin
    if (!tmw_en || tie_low) begin
      ro_en <= 1'b0;
      mcnt  <= 0;
      done  <= 1'b0;
    end else if (!done) begin
      if (!ro_en) begin
        ro_en <= 1'b1;
        mcnt  <= 1;
      end else if (mcnt == int'(tmw_max)) begin
        ro_en <= 1'b0;
        done  <= 1'b1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_clr();
    int k = 0;
    while (!clr && k < 50) begin
      tick();
      k++;
    end
    check("clr_seen", 32'(clr), 1);
  endtask

  // called in a CLEAR cycle; returns at next CLEAR or OUTPUT
  task automatic sample(
    input  logic [15:0] v,
    input  logic [4:0]  mx,
    output int          n,
    output int          hi
  );
    ro_cnt = v;
    n  = 0;
    hi = 0;
    tick();
    n = 1;
    check("max", 32'(tmw_max), 32'(mx));
    check("en_arm", 32'(tmw_en), 1);
    do begin
      if (ro_en) hi++;
      tick();
      n++;
    end while (!clr && !rnd_if.rnd_valid_o && n < 100);
  endtask

  logic [15:0] w1 [8];
  logic [15:0] w2 [8];
  logic [15:0] w3 [8];

  initial begin
    int n, hi;
    int bad_v, bad_d, bad_e, bad_c;
    w1 = '{16'h7, 16'h6, 16'h7, 16'h7,
           16'h6, 16'h6, 16'h7, 16'h6};
    w2 = '{16'h3, 16'h4, 16'h3, 16'h4,
           16'h7, 16'h6, 16'h4, 16'h3};
    w3 = '{16'h7, 16'h7, 16'h7, 16'h7,
           16'h6, 16'h6, 16'h6, 16'h6};

    rst    = 1'b1;
    start  = 1'b0;
    window = 5'd4;
    ro_cnt = '0;
    rnd_if.rnd_ready_i = 1'b1;
    repeat (2) tick();
    check("rst_en", 32'(tmw_en), 0);
    check("rst_max", 32'(tmw_max), 1);
    check("rst_clr", 32'(clr), 0);
    check("rst_data", 32'(rnd_if.rnd_data_o), 0);
    check("rst_valid", 32'(rnd_if.rnd_valid_o), 0);
    check("rst_err", 32'(err), 0);

    rst   = 1'b0;
    start = 1'b1;
    wait_clr();

    // word B2: folds equal LSBs 1,0,1,1,0,0,1,0
    for (int i = 0; i < 8; i++) begin
      sample(w1[i], 5'd4, n, hi);
      check("w1_period", 32'(n), 10);
      check("w1_ro_hi", 32'(hi), 4);
      if (i < 7) check("w1_clr", 32'(clr), 1);
    end
    check("w1_valid", 32'(rnd_if.rnd_valid_o), 1);
    check("w1_data", 32'(rnd_if.rnd_data_o), 32'hB2);
    tick();
    check("w1_next_clr", 32'(clr), 1);
    check("w1_drop", 32'(rnd_if.rnd_valid_o), 0);

    // word 5A: 3-bit fold differs from LSB (A9)
    for (int i = 0; i < 8; i++) begin
      if (i == 7) rnd_if.rnd_ready_i = 1'b0;
      sample(w2[i], 5'd4, n, hi);
      check("w2_period", 32'(n), 10);
      if (i < 7) check("w2_clr", 32'(clr), 1);
    end
    check("w2_valid", 32'(rnd_if.rnd_valid_o), 1);
    check("w2_data", 32'(rnd_if.rnd_data_o), 32'h5A);
    bad_v = 0; bad_d = 0; bad_e = 0; bad_c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rnd_if.rnd_valid_o !== 1'b1) bad_v++;
      if (rnd_if.rnd_data_o !== 8'h5A) bad_d++;
      if (tmw_en !== 1'b0) bad_e++;
      if (clr !== 1'b0) bad_c++;
    end
    check("bp_valid", 32'(bad_v), 0);
    check("bp_data", 32'(bad_d), 0);
    check("bp_en", 32'(bad_e), 0);
    check("bp_clr", 32'(bad_c), 0);
    rnd_if.rnd_ready_i = 1'b1;
    tick();
    check("bp_next_clr", 32'(clr), 1);
    check("bp_drop", 32'(rnd_if.rnd_valid_o), 0);

    // zero window clamps to 1
    window = 5'd0;
    sample(16'h7, 5'd1, n, hi);
    check("zw_period", 32'(n), 7);
    check("zw_ro_hi", 32'(hi), 1);
    check("zw_clr", 32'(clr), 1);
    check("zw_err", 32'(err), 0);
    window = 5'd4;

    // ARM timeout
    tie_low = 1'b1;
    repeat (4) tick();
    check("to_arm_en", 32'(tmw_en), 1);
    check("to_arm_err", 32'(err), 0);
    tick();
    check("to_clr", 32'(clr), 1);
    check("to_err", 32'(err), 1);
    check("to_en", 32'(tmw_en), 0);
    tie_low = 1'b0;

    // reset during RUN
    repeat (3) tick();
    check("run_en", 32'(tmw_en), 1);
    check("run_ro", 32'(ro_en), 1);
    rst = 1'b1;
    tick();
    check("mr_en", 32'(tmw_en), 0);
    check("mr_max", 32'(tmw_max), 1);
    check("mr_clr", 32'(clr), 0);
    check("mr_data", 32'(rnd_if.rnd_data_o), 0);
    check("mr_valid", 32'(rnd_if.rnd_valid_o), 0);
    check("mr_err", 32'(err), 0);
    rst = 1'b0;
    wait_clr();

    // partial word must be gone: a full 8 samples for F0
    for (int i = 0; i < 8; i++) begin
      sample(w3[i], 5'd4, n, hi);
      if (i < 7) check("w3_clr", 32'(clr), 1);
    end
    check("w3_valid", 32'(rnd_if.rnd_valid_o), 1);
    check("w3_data", 32'(rnd_if.rnd_data_o), 32'hF0);
    check("w3_err", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
